// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One shared BCD-to-7-segment decoder is driven per digit slot. Each
// slot opens with a one-cycle anti-ghost gap where all anodes are off.
//
// The displayed value is double-buffered. A load writes the staging register,
// and the staging register is copied into the shadow register only at the
// frame boundary. The last cycle of the last slot is the frame boundary.
//
// Parameters:
//   DIGITS       number of digit positions scanned (2..8)
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//
// Ports:
//   clk         system clock; every register updates on its rising edge
//   rst         synchronous, active-high reset
//   load        single-cycle strobe; captures bcd_in into the staging register
//   bcd_in      packed BCD value; digit k = bits [4k+3:4k]
//   bcd_sel     registered BCD code for the shared decoder
//   an_n        registered active-low anode enables; at most one is low
//   pending     a staged value is waiting for the next frame boundary
//   frame_done  one-cycle pulse after the staged value has been committed
//
// Build option:
//   SEG_LZB_EN  when defined, enables leading-zero blanking. Digit k (k >= 1)
//               is blanked while it and all more-significant shadow digits are
//               zero. A blanked slot keeps all anodes off and drives 4'hF.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [3:0]            bcd_sel,
  output logic [DIGITS-1:0]     an_n,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]          presc, presc_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [4*DIGITS-1:0]    staged, shadow, shadow_nxt;
  logic                   slot_end, boundary, commit;
  logic [3:0]             digit_nxt, sel_nxt;
  logic [DIGITS-1:0]      an_nxt;
  logic                   blank_nxt;

  // Slot and frame sequencing
  always_comb begin
    slot_end  = (presc == PRESC_LAST);
    boundary  = slot_end && (idx == IDX_LAST);
    commit    = boundary && pending;
    presc_nxt = slot_end ? '0 : presc + 1'b1;
    idx_nxt   = idx;
    if (slot_end) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    // The shadow copy happens on the same edge that moves the scan to slot 0.
    // The committed digit 0 therefore appears on bcd_sel immediately.
    shadow_nxt = commit ? staged : shadow;
  end

  // Digit selection for the slot the outputs will describe after this edge
  always_comb begin
    digit_nxt = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        digit_nxt = shadow_nxt[4*k +: 4];
      end
    end
  end

`ifdef SEG_LZB_EN
  logic [DIGITS-1:0] upper_zero;
  logic              zero_acc;

  // upper_zero[k]: shadow digits k..DIGITS-1 are all zero
  always_comb begin
    zero_acc   = 1'b1;
    upper_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_acc      = zero_acc & (shadow_nxt[4*k +: 4] == 4'h0);
      upper_zero[k] = zero_acc;
    end
  end

  always_comb begin
    blank_nxt = 1'b0;
    for (int k = 1; k < DIGITS; k++) begin
      if (idx_nxt == IW'(k) && upper_zero[k]) begin
        blank_nxt = 1'b1;
      end
    end
  end
`else
  always_comb begin
    blank_nxt = 1'b0;
  end
`endif

  // Output decode: presc == 0 is the anti-ghost gap of every slot
  always_comb begin
    sel_nxt = blank_nxt ? 4'hF : digit_nxt;
    an_nxt  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_nxt == IW'(k) && presc_nxt != '0 && !blank_nxt) begin
        an_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      staged     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      bcd_sel    <= 4'h0;
      an_n       <= '1;
    end else begin
      presc      <= presc_nxt;
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      frame_done <= commit;
      bcd_sel    <= sel_nxt;
      an_n       <= an_nxt;
      if (load) begin
        staged <= bcd_in;
      end
      // A load on the boundary cycle takes priority over the commit clear.
      if (load) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
